lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; the memory side has a fixed 1-cycle registered read latency.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; asynchronous and active-low.
REQ-004 req  in  1  CPU access request; sampled only in IDLE.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-007 uns  in  1  load zero-extend when 1, sign-extend when 0.
REQ-008 addr  in  32  byte address.
REQ-009 wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 busy  out  1  high whenever state is not IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  valid with done; 1 = misaligned or illegal size, no memory access made.
REQ-013 rdata  out  32  load result, extended; held until the next load completes.
REQ-014 mem_addr  out  32  word address to data memory, {latched addr[31:2], 2'b00}.
REQ-015 mem_wdata  out  32  word written to data memory.
REQ-016 MemRead  out  1  memory read strobe.
REQ-017 MemWrite  out  1  memory write strobe.
REQ-018 mem_rdata  in  32  memory read word, valid in the cycle after MemRead.

Function
REQ-019 The FSM SHALL have states IDLE, RD_REQ, RD_CAPT, WR, DONE.
REQ-020 In IDLE with req=1, addr, we, size, uns, and wdata SHALL latch; the next state follows from the access type.
- Misaligned or illegal access: DONE with err=1.
- Load or sub-word store: RD_REQ.
- Word store: WR.
REQ-021 Misaligned SHALL mean:
- size=01 with addr[0]=1.
- size=10 with addr[1:0]!=0.
- size=11 always.
REQ-022 RD_REQ SHALL assert MemRead=1 for exactly one cycle, then go to RD_CAPT.
REQ-023 RD_CAPT SHALL sample mem_rdata.
- Load: extract the lane, extend it, register it into rdata, go to DONE.
- Sub-word store: merge wdata into the selected lane of mem_rdata, register it as mem_wdata, go to WR.
REQ-024 Byte lane SHALL be addr[1:0] (little-endian, lane 0 = [7:0]); halfword lane SHALL be addr[1] (0 = [15:0]).
REQ-025 WR SHALL assert MemWrite=1 for exactly one cycle with the final mem_wdata (wdata for a word store), then go to DONE.
REQ-026 DONE SHALL drive done=1 for one cycle, then return to IDLE; err=0 except on the misaligned path.
REQ-027 MemRead and MemWrite SHALL never be high together, and SHALL be 0 in IDLE and DONE.
REQ-028 req SHALL be ignored while busy=1, including in DONE; a new request is accepted no earlier than the cycle after DONE.
REQ-029 Latency from the req-accept edge to done=1 SHALL be:
- Load: 3 cycles.
- Word store: 2 cycles.
- Sub-word store: 4 cycles.
- Error: 1 cycle.
REQ-030 rdata SHALL change only in RD_CAPT of a load; stores and errors leave it unchanged.

Reset
REQ-031 rst_n=0 SHALL immediately force the following, regardless of clk:
- state=IDLE.
- busy=0, done=0, err=0.
- rdata=0, mem_addr=0, mem_wdata=0.
- MemRead=0, MemWrite=0.
REQ-032 Reset mid-operation SHALL abort the access; no MemWrite is issued for it after rst_n rises.

Verification
REQ-033 Word 0x00000010 = 0x8899AABB; load size=00, uns=0, addr=0x11 -> MemRead in cycle 1, done at cycle 3, rdata=0xFFFFFFAA, err=0.
REQ-034 Same word; load size=01, uns=1, addr=0x12 -> rdata=0x00008899.
REQ-035 Same word; store size=00, addr=0x13, wdata=0x55 -> MemRead in cycle 1, MemWrite in cycle 3 with mem_wdata=0x5599AABB, done at cycle 4.
REQ-036 Store size=10, addr=0x20, wdata=0xDEADBEEF -> MemWrite in cycle 1 with mem_addr=0x20, no MemRead, done at cycle 2; readback returns 0xDEADBEEF.
REQ-037 Load size=10, addr=0x22 -> done=1 with err=1 at cycle 1, no MemRead or MemWrite, rdata unchanged.
REQ-038 Sub-word store with rst_n pulsed low in RD_CAPT -> outputs cleared at once, MemWrite never asserted, memory word unchanged; req held high during busy is not re-accepted until IDLE.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller for a 32-bit data memory with a
// 1-cycle registered read. Loads and sub-word stores read the addressed word
// first; sub-word stores then write back the merged word (read-modify-write).
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_CAPT = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]  state;
  logic        we_q;
  logic        uns_q;
  logic        err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  // Halfword must be 2-byte aligned, word 4-byte aligned; size 11 is never legal.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    logic m;
    m = 1'b0;
    case (sz)
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      2'b11:   m = 1'b1;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Pick the addressed lane out of the memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] a, input logic u);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [31:0] s;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   s = u ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   s = u ? {16'd0, h} : {{16{h[15]}}, h};
      default: s = word;
    endcase
    return s;
  endfunction

  // Overlay the right-aligned store data onto its lane of the old memory word.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] a);
    logic [31:0] m;
    m = word;
    if (sz == 2'b00) m[{a, 3'b000} +: 8] = wd[7:0];
    else             m[{a[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  // Access sequencer: latches the request, walks read/capture/write, holds results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata     <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q      <= we;
            uns_q     <= uns;
            size_q    <= size;
            addr_q    <= addr;
            wdata_q   <= wdata;
            mem_wdata <= wdata;
            err_q     <= misaligned(size, addr[1:0]);
            if (misaligned(size, addr[1:0])) state <= DONE;
            else if (!we || size != 2'b10)   state <= RD_REQ;
            else                             state <= WR;
          end
        end
        RD_REQ:  state <= RD_CAPT;
        RD_CAPT: begin
          if (!we_q) begin
            rdata <= load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
            state <= DONE;
          end else begin
            mem_wdata <= merge_store(mem_rdata, wdata_q, size_q, addr_q[1:0]);
            state     <= WR;
          end
        end
        WR:      state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and status decode straight from state so reset clears them at once.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    err      = (state == DONE) && err_q;
    MemRead  = (state == RD_REQ);
    MemWrite = (state == WR);
    mem_addr = {addr_q[31:2], 2'b00};
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized load/store accesses against a word-level
// reference of memory and load results, with a registered-read memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, err, MemRead, MemWrite;
  logic [31:0] rdata, mem_addr, mem_wdata;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] exp_rdata;
  int          vecs = 0;
  int          miscmp = 0;

  lsu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: registered read, synchronous write, backdoor fill port.
  always @(posedge clk) begin
    if (MemRead) mem_rdata <= mem[mem_addr[9:2]];
    if (MemWrite) mem[mem_addr[9:2]] <= mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [1:0] sz, input logic u);
    logic [31:0] x;
    if (sz == 2'd0) begin
      x = word >> (int'(a[1:0]) * 8);
      return u ? {24'd0, x[7:0]} : {{24{x[7]}}, x[7:0]};
    end else if (sz == 2'd1) begin
      x = word >> (int'(a[1]) * 16);
      return u ? {16'd0, x[15:0]} : {{16{x[15]}}, x[15:0]};
    end
    return word;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (sz == 2'd0) ? int'(a[1:0]) * 8 : (sz == 2'd1) ? int'(a[1]) * 16 : 0;
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // One complete access; hold keeps req high until the unit is idle again.
  task automatic acc(input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic hold);
    logic        mis, err_seen, addr_bad, busy_bad;
    int          lat, rd_n, wr_n, ov, done_c;
    logic [7:0]  idx;
    logic [31:0] old, exp_word, wr_data;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    idx = a[9:2];
    old = ref_mem[idx];
    exp_word = old;
    if (mis)            lat = 1;
    else if (!w)        lat = 3;
    else if (sz == 2'd2) lat = 2;
    else                lat = 4;
    if (!mis && !w) exp_rdata = ref_load(old, a, sz, u);
    if (!mis && w)  exp_word  = ref_store(old, a, sz, wd);
    ref_mem[idx] = exp_word;
    rd_n = 0; wr_n = 0; ov = 0; done_c = -1;
    err_seen = 1'b0; addr_bad = 1'b0; busy_bad = 1'b0; wr_data = 32'd0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (MemRead) rd_n++;
      if (MemWrite) begin wr_n++; wr_data = mem_wdata; end
      if ((MemRead || MemWrite) && mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
      if (MemRead && MemWrite) ov++;
      if (done === 1'b1 && done_c < 0) begin done_c = c; err_seen = err; end
      if ((c <= lat && busy !== 1'b1) || (c == lat + 1 && busy !== 1'b0)) busy_bad = 1'b1;
      if (!hold || c == lat + 1) req = 1'b0;
    end
    chk("done_cycle", 32'(done_c), 32'(lat));
    chk("err", 32'(err_seen), 32'(mis));
    chk("memread_count", 32'(rd_n), 32'(!mis && (!w || sz != 2'd2)));
    chk("memwrite_count", 32'(wr_n), 32'(w && !mis));
    chk("strobe_overlap", 32'(ov), 32'd0);
    chk("mem_addr", 32'(addr_bad), 32'd0);
    chk("busy", 32'(busy_bad), 32'd0);
    chk("write_data", wr_data, (w && !mis) ? exp_word : 32'd0);
    chk("rdata", rdata, exp_rdata);
    chk("mem_word", mem[idx], exp_word);
  endtask

  initial begin
    int wcnt;
    rst_n = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0; bd_we = 1'b0; bd_idx = 8'd0; bd_data = 32'd0;
    exp_rdata = 32'd0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_flags", {27'd0, busy, done, err, MemRead, MemWrite}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);

    // fill memory through the backdoor while the unit is held in reset
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 8'(i);
      bd_data = (i == 4) ? 32'h8899AABB : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    rst_n = 1'b1;

    // directed examples
    acc(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b0);
    chk("ex_lb_signed", rdata, 32'hFFFFFFAA);
    acc(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b0);
    chk("ex_lhu", rdata, 32'h00008899);
    acc(1'b1, 2'd0, 1'b0, 32'h13, 32'h55, 1'b0);
    chk("ex_sb_word", mem[4], 32'h5599AABB);
    acc(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
    acc(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1);
    chk("ex_sw_readback", rdata, 32'hDEADBEEF);
    acc(1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b0);
    chk("ex_misaligned_rdata_kept", rdata, 32'hDEADBEEF);
    acc(1'b1, 2'd3, 1'b0, 32'h40, 32'h1234, 1'b1);

    // randomized accesses
    for (int n = 0; n < 80; n++) begin
      acc(1'(($urandom)), 2'($urandom_range(0, 3)), 1'($urandom), $urandom, $urandom,
          1'($urandom));
    end

    // reset in the capture cycle of a sub-word store aborts it
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h41; wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_flags", {27'd0, busy, done, err, MemRead, MemWrite}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_wdata", mem_wdata, 32'd0);
    req = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wcnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (MemWrite || busy) wcnt++;
    end
    chk("abort_no_write", 32'(wcnt), 32'd0);
    chk("abort_mem_word", mem[16], ref_mem[16]);

    // unit resumes normally after the abort
    acc(1'b1, 2'd1, 1'b0, 32'h42, 32'hCAFE, 1'b0);
    acc(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b0);
    chk("resume_lh", rdata, 32'hFFFFCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
